// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between an instruction-fetch read
// port (i_*) and a data load/store port (d_*). The data port normally has
// priority; a saturating starvation counter forces the instruction port to win
// once it has been denied STARVE_LIMIT consecutive cycles.
//
// Optional feature (compile-time macro MEM_ARB_RMW_EN):
//   When defined, data stores with d_be != 4'hF become a two-cycle
//   read-modify-write: read the word, then write back the byte-merged word.
//   When undefined, d_be is ignored and every store is a single-cycle
//   full-word write.
//
// Parameters:
//   STARVE_LIMIT   consecutive lost cycles before the instruction port wins
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   i_req/i_addr   instruction read request and byte address
//   i_ready        combinational grant for the instruction port (IDLE only)
//   i_rvalid       one-cycle read-data strobe, i_rdata valid with it
//   d_req/d_we     data request, write enable
//   d_addr/d_wdata data byte address and store data
//   d_be           store byte enables (used only with MEM_ARB_RMW_EN)
//   d_ready        combinational grant for the data port (IDLE only)
//   d_rvalid       one-cycle load-data strobe, d_rdata valid with it
//   m_address      memory word address (byte address passed through unchanged)
//   m_write        memory write strobe, committed at the next rising edge
//   m_write_data   memory write data
//   m_read_data    memory read data, registered one cycle after m_address
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   // instruction-fetch read port
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic        i_rvalid,
   output logic [31:0] i_rdata,
   // data load/store port
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_be,
   output logic        d_ready,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   // memory side
   output logic [31:0] m_address,
   output logic        m_write,
   output logic [31:0] m_write_data,
   input  logic [31:0] m_read_data
);

   // Counter wide enough to hold STARVE_LIMIT itself (saturation value).
   localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   // RMW_WR is kept as an encoding only: the merged write is issued from
   // RMW_RD, which returns straight to IDLE.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      READ   = 2'd1,
      RMW_RD = 2'd2,
      RMW_WR = 2'd3
   } state_t;

   state_t           state_q,      state_d;
   logic             owner_d_q,    owner_d_d;     // 1: READ belongs to d port
   logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
   logic             i_grant;

`ifdef MEM_ARB_RMW_EN
   logic [31:0]      cap_addr_q,   cap_addr_d;
   logic [31:0]      cap_wdata_q,  cap_wdata_d;
   logic [3:0]       cap_be_q,     cap_be_d;
`else
   // Byte enables have no effect when partial stores are not supported.
   logic             unused_be;
   assign unused_be = ^d_be;
`endif

   // Read data is routed to both ports; only the owner's rvalid qualifies it.
   assign i_rdata = m_read_data;
   assign d_rdata = m_read_data;

   // --------------------------------------------------------------------------
   // Next-state, arbitration and memory-side decode
   // --------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal assigned below gets a default first, so no path
      // through the case/if tree can leave it unassigned and infer a latch.
      state_d      = state_q;
      owner_d_d    = owner_d_q;
      starve_cnt_d = starve_cnt_q;
`ifdef MEM_ARB_RMW_EN
      cap_addr_d   = cap_addr_q;
      cap_wdata_d  = cap_wdata_q;
      cap_be_d     = cap_be_q;
`endif
      i_ready      = 1'b0;
      d_ready      = 1'b0;
      i_rvalid     = 1'b0;
      d_rvalid     = 1'b0;
      m_write      = 1'b0;
      m_address    = d_addr;
      m_write_data = d_wdata;
      i_grant      = 1'b0;

      case (state_q)
         IDLE: begin
            // d has priority unless i has been starved up to the limit.
            if (i_req && (!d_req || starve_cnt_q == CNT_MAX)) begin
               i_grant   = 1'b1;
               i_ready   = 1'b1;
               m_address = i_addr;
               owner_d_d = 1'b0;
               state_d   = READ;
            end else if (d_req) begin
               d_ready   = 1'b1;
               m_address = d_addr;
               if (!d_we) begin
                  owner_d_d = 1'b1;
                  state_d   = READ;
               end else begin
`ifdef MEM_ARB_RMW_EN
                  if (d_be != 4'hF) begin
                     // Partial store: issue the read now, merge next cycle.
                     cap_addr_d  = d_addr;
                     cap_wdata_d = d_wdata;
                     cap_be_d    = d_be;
                     state_d     = RMW_RD;
                  end else begin
                     m_write = 1'b1;
                  end
`else
                  m_write = 1'b1;
`endif
               end
            end
         end

         READ: begin
            if (owner_d_q) d_rvalid = 1'b1;
            else           i_rvalid = 1'b1;
            state_d = IDLE;
         end

         RMW_RD: begin
`ifdef MEM_ARB_RMW_EN
            // Old word arrives now; write back enabled bytes from the store.
            m_write   = 1'b1;
            m_address = cap_addr_q;
            for (int k = 0; k < 4; k++) begin
               m_write_data[8*k +: 8] = cap_be_q[k] ? cap_wdata_q[8*k +: 8]
                                                    : m_read_data[8*k +: 8];
            end
`endif
            state_d = IDLE;
         end

         RMW_WR:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Starvation count tracks consecutive cycles i asks and is refused.
      if (i_req && !i_grant) begin
         if (starve_cnt_q != CNT_MAX) starve_cnt_d = starve_cnt_q + 1'b1;
      end else begin
         starve_cnt_d = '0;
      end

      // Reset must silence handshakes and memory writes immediately, even
      // though it is asynchronous to the state registers' next update.
      if (reset) begin
         i_ready  = 1'b0;
         d_ready  = 1'b0;
         i_rvalid = 1'b0;
         d_rvalid = 1'b0;
         m_write  = 1'b0;
      end
   end

   // --------------------------------------------------------------------------
   // State registers
   // --------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         owner_d_q    <= 1'b0;
         starve_cnt_q <= '0;
`ifdef MEM_ARB_RMW_EN
         cap_addr_q   <= '0;
         cap_wdata_q  <= '0;
         cap_be_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         owner_d_q    <= owner_d_d;
         starve_cnt_q <= starve_cnt_d;
`ifdef MEM_ARB_RMW_EN
         cap_addr_q   <= cap_addr_d;
         cap_wdata_q  <= cap_wdata_d;
         cap_be_q     <= cap_be_d;
`endif
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a small synchronous memory model
// (writes commit at the edge, reads registered one cycle after the address).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge. Partial-store expectations follow MEM_ARB_RMW_EN.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_ready;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_be;
   logic        d_ready;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic [31:0] m_address;
   logic        m_write;
   logic [31:0] m_write_data;
   logic [31:0] m_read_data;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:255];

   mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_ready      (i_ready),
      .i_rvalid     (i_rvalid),
      .i_rdata      (i_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_be         (d_be),
      .d_ready      (d_ready),
      .d_rvalid     (d_rvalid),
      .d_rdata      (d_rdata),
      .m_address    (m_address),
      .m_write      (m_write),
      .m_write_data (m_write_data),
      .m_read_data  (m_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port memory: registered read, write at the edge.
   always @(posedge clk) begin
      if (m_write) mem[m_address[9:2]] <= m_write_data;
      m_read_data <= mem[m_address[9:2]];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_req   = 1'b0;
      i_addr  = 32'h0;
      d_req   = 1'b0;
      d_we    = 1'b0;
      d_addr  = 32'h0;
      d_wdata = 32'h0;
      d_be    = 4'h0;
   endtask

   initial begin
      for (int w = 0; w < 256; w++) mem[w] = 32'h0;
      mem[4]  = 32'hDEADBEEF;   // byte address 0x10
      mem[12] = 32'hAABBCCDD;   // byte address 0x30
      m_read_data = 32'h0;

      // Reset with every request active: nothing may be granted or written.
      reset   = 1'b1;
      i_req   = 1'b1;
      i_addr  = 32'h10;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h20;
      d_wdata = 32'hFFFFFFFF;
      d_be    = 4'hF;
      @(negedge clk);
      check("rst_i_ready",  32'(i_ready),  32'h0);
      check("rst_d_ready",  32'(d_ready),  32'h0);
      check("rst_i_rvalid", 32'(i_rvalid), 32'h0);
      check("rst_d_rvalid", 32'(d_rvalid), 32'h0);
      check("rst_m_write",  32'(m_write),  32'h0);
      check("rst_state",    32'(dut.state_q), 32'h0);
      next_cycle();
      idle_inputs();
      reset = 1'b0;
      next_cycle();

      // Instruction read of 0x10.
      i_req  = 1'b1;
      i_addr = 32'h10;
      @(negedge clk);
      check("i_rd_ready_T",  32'(i_ready), 32'h1);
      check("i_rd_dready_T", 32'(d_ready), 32'h0);
      check("i_rd_mwrite_T", 32'(m_write), 32'h0);
      check("i_rd_addr_T",   m_address,    32'h10);
      next_cycle();
      @(negedge clk);
      check("i_rd_rvalid_T1", 32'(i_rvalid), 32'h1);
      check("i_rd_rdata_T1",  i_rdata,       32'hDEADBEEF);
      check("i_rd_ready_T1",  32'(i_ready),  32'h0);
      check("i_rd_drv_T1",    32'(d_rvalid), 32'h0);
      next_cycle();
      idle_inputs();
      next_cycle();

      // Full-word data store to 0x20.
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h20;
      d_wdata = 32'h12345678;
      d_be    = 4'hF;
      @(negedge clk);
      check("d_wr_ready_T", 32'(d_ready), 32'h1);
      check("d_wr_mwrite",  32'(m_write), 32'h1);
      check("d_wr_addr",    m_address,    32'h20);
      check("d_wr_data",    m_write_data, 32'h12345678);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("d_wr_no_rvalid", 32'(d_rvalid), 32'h0);
      check("d_wr_mwrite_T1", 32'(m_write),  32'h0);
      next_cycle();

      // Load back through an unaligned byte address: low bits pass through.
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h22;
      @(negedge clk);
      check("d_rd_ready_T", 32'(d_ready), 32'h1);
      check("d_rd_addr_T",  m_address,    32'h22);
      check("d_rd_mwr_T",   32'(m_write), 32'h0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("d_rd_rvalid", 32'(d_rvalid), 32'h1);
      check("d_rd_rdata",  d_rdata,       32'h12345678);
      check("d_rd_irv",    32'(i_rvalid), 32'h0);
      next_cycle();

      // Partial store to 0x30 with byte enables 0101.
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h30;
      d_wdata = 32'h11223344;
      d_be    = 4'b0101;
`ifdef MEM_ARB_RMW_EN
      @(negedge clk);
      check("rmw_ready_T",  32'(d_ready), 32'h1);
      check("rmw_mwrite_T", 32'(m_write), 32'h0);
      check("rmw_addr_T",   m_address,    32'h30);
      next_cycle();
      @(negedge clk);
      check("rmw_ready_T1",  32'(d_ready), 32'h0);
      check("rmw_mwrite_T1", 32'(m_write), 32'h1);
      check("rmw_addr_T1",   m_address,    32'h30);
      check("rmw_data_T1",   m_write_data, 32'hAA22CC44);
      check("rmw_rvalid_T1", 32'(d_rvalid), 32'h0);
      next_cycle();
      idle_inputs();
`else
      @(negedge clk);
      check("pw_ready_T",  32'(d_ready), 32'h1);
      check("pw_mwrite_T", 32'(m_write), 32'h1);
      check("pw_data_T",   m_write_data, 32'h11223344);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("pw_mwrite_T1", 32'(m_write), 32'h0);
`endif
      next_cycle();
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h30;
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("pw_rb_rvalid", 32'(d_rvalid), 32'h1);
`ifdef MEM_ARB_RMW_EN
      check("pw_rb_data", d_rdata, 32'hAA22CC44);
`else
      check("pw_rb_data", d_rdata, 32'h11223344);
`endif
      next_cycle();

      // Starvation: both request continuously; d stores win 4 cycles, then i.
      i_req   = 1'b1;
      i_addr  = 32'h10;
      d_req   = 1'b1;
      d_we    = 1'b1;
      d_addr  = 32'h40;
      d_wdata = 32'h0BADF00D;
      d_be    = 4'hF;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("stv_d_ready_%0d", c), 32'(d_ready), 32'h1);
         check($sformatf("stv_i_ready_%0d", c), 32'(i_ready), 32'h0);
         next_cycle();
      end
      @(negedge clk);
      check("stv_i_win",    32'(i_ready), 32'h1);
      check("stv_d_lose",   32'(d_ready), 32'h0);
      check("stv_mwrite",   32'(m_write), 32'h0);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      check("stv_cnt_clr",  32'(dut.starve_cnt_q), 32'h0);
      check("stv_i_rvalid", 32'(i_rvalid), 32'h1);
      check("stv_i_rdata",  i_rdata,       32'hDEADBEEF);
      next_cycle();

      // Reset during the READ cycle of a data load.
      d_req  = 1'b1;
      d_we   = 1'b0;
      d_addr = 32'h20;
      @(negedge clk);
      check("abort_ready_T", 32'(d_ready), 32'h1);
      next_cycle();
      idle_inputs();
      reset = 1'b1;
      @(negedge clk);
      check("abort_d_rvalid", 32'(d_rvalid), 32'h0);
      check("abort_m_write",  32'(m_write),  32'h0);
      check("abort_state",    32'(dut.state_q), 32'h0);
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      check("abort_post_rv", 32'(d_rvalid), 32'h0);
      next_cycle();
      i_req  = 1'b1;
      i_addr = 32'h10;
      @(negedge clk);
      check("post_i_ready", 32'(i_ready), 32'h1);
      next_cycle();
      i_req = 1'b0;
      @(negedge clk);
      check("post_i_rvalid", 32'(i_rvalid), 32'h1);
      check("post_i_rdata",  i_rdata,       32'hDEADBEEF);
      next_cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
